// File: rtl/vga_rx_monitor.sv
// Receive-side VGA checker: recovers X/Y from sync edges, verifies line/frame
// timing, declares lock, samples one probe pixel and counts red pixels per frame.
module vga_rx_monitor #(
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned H_START     = 144,
    parameter int unsigned V_START     = 35,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter logic        SYNC_POL    = 1'b0,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [2:0]  rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    output logic        locked,
    output logic        active,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [2:0]  probe_rgb,
    output logic        probe_valid,
    output logic        frame_done,
    output logic [18:0] red_count,
    output logic [7:0]  err_count
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        LOCKED
    } state_t;

    state_t      state;
    logic        hs_prev;
    logic        vs_prev;
    logic [9:0]  hcnt;
    logic [9:0]  vcnt;
    logic [10:0] line_cnt;
    logic [3:0]  good_frames;
    logic [18:0] red_acc;

    logic        hs_edge;
    logic        vs_edge;
    logic [9:0]  hcnt_nxt;
    logic [9:0]  vcnt_nxt;
    logic [10:0] frame_lines;
    logic        line_bad;
    logic        frame_bad;
    logic        bad;
    logic        win_h;
    logic        win_v;
    logic        act_now;
    logic [9:0]  px_now;
    logic [9:0]  py_now;
    logic        red_now;
    logic        probe_hit;
    logic        lock_hit;

    always_comb begin
        hs_edge  = (h_sync == SYNC_POL) && (hs_prev != SYNC_POL);
        vs_edge  = (v_sync == SYNC_POL) && (vs_prev != SYNC_POL);

        hcnt_nxt = hs_edge ? '0 : ((hcnt == '1) ? hcnt : hcnt + 10'd1);
        vcnt_nxt = vcnt;
        if (vs_edge)
            vcnt_nxt = '0;
        else if (hs_edge && vcnt != '1)
            vcnt_nxt = vcnt + 10'd1;

        // The hs edge coincident with this vs edge closes the frame, so it is counted here.
        frame_lines = line_cnt + 11'(hs_edge);
        line_bad    = hs_edge && (hcnt != H_LAST);
        frame_bad   = vs_edge && (32'(frame_lines) != V_TOTAL);
        bad         = line_bad || frame_bad;

        win_h   = (32'(hcnt_nxt) >= H_START) && (32'(hcnt_nxt) < H_START + H_ACTIVE);
        win_v   = (32'(vcnt_nxt) >= V_START) && (32'(vcnt_nxt) < V_START + V_ACTIVE);
        act_now = (state == LOCKED) && win_h && win_v;
        px_now  = act_now ? 10'(32'(hcnt_nxt) - H_START) : '0;
        py_now  = act_now ? 10'(32'(vcnt_nxt) - V_START) : '0;
        red_now = act_now && rgb[2];

        probe_hit = act_now && (px_now == probe_x) && (py_now == probe_y);
        lock_hit  = (32'(good_frames) + 1) >= LOCK_FRAMES;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            hs_prev     <= ~SYNC_POL;
            vs_prev     <= ~SYNC_POL;
            hcnt        <= '0;
            vcnt        <= '0;
            line_cnt    <= '0;
            good_frames <= '0;
            red_acc     <= '0;
            locked      <= 1'b0;
            active      <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            probe_rgb   <= '0;
            probe_valid <= 1'b0;
            frame_done  <= 1'b0;
            red_count   <= '0;
            err_count   <= '0;
        end else begin
            probe_valid <= 1'b0;
            frame_done  <= 1'b0;
            if (pix_en) begin
                hs_prev <= h_sync;
                vs_prev <= v_sync;
                hcnt    <= hcnt_nxt;
                vcnt    <= vcnt_nxt;
                if (vs_edge)
                    line_cnt <= '0;
                else if (hs_edge && line_cnt != '1)
                    line_cnt <= line_cnt + 11'd1;

                active <= act_now;
                pix_x  <= px_now;
                pix_y  <= py_now;

                if (probe_hit) begin
                    probe_rgb   <= rgb;
                    probe_valid <= 1'b1;
                end

                if (red_now)
                    red_acc <= red_acc + 19'd1;

                case (state)
                    SEARCH: begin
                        if (vs_edge) begin
                            state       <= TRAIN;
                            good_frames <= '0;
                        end
                    end
                    TRAIN: begin
                        if (bad) begin
                            good_frames <= '0;
                        end else if (vs_edge) begin
                            if (lock_hit) begin
                                state   <= LOCKED;
                                locked  <= 1'b1;
                                red_acc <= '0;
                            end else begin
                                good_frames <= good_frames + 4'd1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (bad) begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                            if (err_count != '1)
                                err_count <= err_count + 8'd1;
                        end else if (vs_edge) begin
                            red_count  <= red_acc + 19'(red_now);
                            red_acc    <= '0;
                            frame_done <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a tiny 20x10 timing and a scoreboard queue.
module tb_vga_rx_monitor;

    localparam int HT = 20;
    localparam int HS = 4;
    localparam int VS = 2;
    localparam int HA = 12;
    localparam int VA = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        h_sync;
    logic        v_sync;
    logic [2:0]  rgb;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic        locked;
    logic        active;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [2:0]  probe_rgb;
    logic        probe_valid;
    logic        frame_done;
    logic [18:0] red_count;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .H_TOTAL(20), .V_TOTAL(10), .H_START(4), .V_START(2),
        .H_ACTIVE(12), .V_ACTIVE(6), .SYNC_POL(1'b0), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync), .v_sync(v_sync),
        .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .locked(locked),
        .active(active), .pix_x(pix_x), .pix_y(pix_y), .probe_rgb(probe_rgb),
        .probe_valid(probe_valid), .frame_done(frame_done), .red_count(red_count),
        .err_count(err_count)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [18:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pv_seen = 0;

    bit          m_locked;
    logic [7:0]  m_err;
    logic [18:0] m_red_count;
    logic [18:0] m_red_acc;
    logic [2:0]  m_probe_rgb;

    function automatic logic [18:0] observe(input int sel);
        case (sel)
            0: return 19'(locked);
            1: return 19'(active);
            2: return 19'(pix_x);
            3: return 19'(pix_y);
            4: return 19'(probe_rgb);
            5: return 19'(probe_valid);
            6: return 19'(frame_done);
            7: return red_count;
            8: return 19'(err_count);
            9: return 19'(pv_seen);
            default: return '1;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [18:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [18:0] o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        pix_en = 1'b0;
        m_locked    = 1'b0;
        m_err       = '0;
        m_red_count = '0;
        m_red_acc   = '0;
        m_probe_rgb = '0;
        expect_val("rst_locked", 0, '0);
        expect_val("rst_active", 1, '0);
        expect_val("rst_pix_x", 2, '0);
        expect_val("rst_pix_y", 3, '0);
        expect_val("rst_probe_rgb", 4, '0);
        expect_val("rst_probe_valid", 5, '0);
        expect_val("rst_frame_done", 6, '0);
        expect_val("rst_red_count", 7, '0);
        expect_val("rst_err_count", 8, '0);
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One generated frame; lock_entry is the lock level expected right after its vs edge.
    task automatic frame(input int nlines, input int short_line, input bit lock_entry,
                         input bit red_box, input bit probe_draw, input int reset_line);
        int         plen;
        int         ax;
        int         ay;
        bit         lb;
        bit         act;
        bit         fd;
        bit         pv;
        logic [2:0] c;
        for (int ln = 0; ln < nlines; ln++) begin
            plen = (ln == short_line) ? HT - 1 : HT;
            for (int p = 0; p < plen; p++) begin
                if (ln == reset_line && p == 7)
                    do_reset();
                ax = p - HS;
                ay = ln - VS;
                c  = 3'b000;
                if (red_box && ax >= 4 && ax <= 6 && ay >= 1 && ay <= 2)
                    c = 3'b100;
                if (probe_draw && ax == 11 && ay == 5)
                    c = 3'b010;
                lb = m_locked;
                if (ln == 0 && p == 0)
                    m_locked = lock_entry;
                if (short_line >= 0 && ln == short_line + 1 && p == 0 && lb) begin
                    m_locked = 1'b0;
                    if (m_err != 8'hFF)
                        m_err++;
                end
                act = lb && ax >= 0 && ax < HA && ay >= 0 && ay < VA;
                fd  = (ln == 0 && p == 0) && lb && m_locked;
                if (fd)
                    m_red_count = m_red_acc;
                if (ln == 0 && p == 0)
                    m_red_acc = '0;
                if (act && c[2])
                    m_red_acc++;
                pv = act && ax == int'(probe_x) && ay == int'(probe_y);
                if (pv)
                    m_probe_rgb = c;

                @(negedge clk);
                h_sync = (p < 2) ? 1'b0 : 1'b1;
                v_sync = (ln < 2) ? 1'b0 : 1'b1;
                rgb    = c;
                pix_en = 1'b1;
                expect_val("locked", 0, 19'(m_locked));
                expect_val("active", 1, 19'(act));
                expect_val("pix_x", 2, act ? 19'(ax) : '0);
                expect_val("pix_y", 3, act ? 19'(ay) : '0);
                expect_val("probe_rgb", 4, 19'(m_probe_rgb));
                expect_val("probe_valid", 5, 19'(pv));
                expect_val("frame_done", 6, 19'(fd));
                expect_val("red_count", 7, m_red_count);
                expect_val("err_count", 8, 19'(m_err));
                @(posedge clk);
                #1;
                if (probe_valid === 1'b1)
                    pv_seen++;
                drain();

                @(negedge clk);
                pix_en = 1'b0;
                expect_val("probe_valid_pulse", 5, '0);
                expect_val("frame_done_pulse", 6, '0);
                expect_val("locked_hold", 0, 19'(m_locked));
                @(posedge clk);
                #1;
                drain();
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        pix_en  = 1'b0;
        h_sync  = 1'b1;
        v_sync  = 1'b1;
        rgb     = 3'b000;
        probe_x = 10'd12;
        probe_y = 10'd0;
        do_reset();

        // Ideal timing: lock after the third vs edge.
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b1, 1'b0, 1'b0, -1);

        // Red 3x2 box, reported at the following frame_done.
        frame(10, -1, 1'b1, 1'b1, 1'b0, -1);
        frame(10, -1, 1'b1, 1'b0, 1'b0, -1);
        expect_val("red_box_total", 7, 19'd6);
        expect_val("probe_out_of_range", 9, '0);
        drain();

        // Probe at the last active pixel of the last active line.
        pv_seen = 0;
        probe_x = 10'd11;
        probe_y = 10'd5;
        frame(10, -1, 1'b1, 1'b0, 1'b1, -1);
        expect_val("probe_capture", 4, 19'(3'b010));
        expect_val("probe_once", 9, 19'd1);
        drain();
        probe_x = 10'd11;
        probe_y = 10'd6;

        // Short line while locked, then relock after three vs edges.
        frame(10, 4, 1'b1, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b1, 1'b1, 1'b0, -1);
        expect_val("err_after_relock", 8, 19'd1);
        expect_val("relocked", 0, 19'd1);
        drain();

        // Reset mid-frame while locked.
        frame(10, -1, 1'b1, 1'b1, 1'b0, 5);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b1, 1'b0, 1'b0, -1);

        // Eleven-line frame during training.
        do_reset();
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(11, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b0, 1'b0, 1'b0, -1);
        frame(10, -1, 1'b1, 1'b0, 1'b0, -1);
        expect_val("train_err_zero", 8, '0);
        expect_val("train_relocked", 0, 19'd1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
